// File: rtl/tec8_pkg.sv
// rtl/tec8_pkg.sv - shared beat/phase encodings and opcode width for the TEC-8 sequencer
package tec8_pkg;

  localparam int IR_W = 4;

  typedef enum logic [1:0] {
    W1 = 2'd0,
    W2 = 2'd1,
    W3 = 2'd2
  } beat_e;

  typedef enum logic [1:0] {
    T1 = 2'd0,
    T2 = 2'd1,
    T3 = 2'd2
  } phase_e;

  // short beats long when the controller raises both in the same T3
  function automatic beat_e next_beat(beat_e cur, logic short_req, logic long_req);
    beat_e nxt;
    case (cur)
      W1:      nxt = short_req ? W1 : W2;
      W2:      nxt = long_req ? W3 : W1;
      default: nxt = W1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/tec8_pulse_sync.sv
// rtl/tec8_pulse_sync.sv - N-stage synchronizer with single-cycle rising-edge pulse
module tec8_pulse_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic async_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/tec8_timing_gen.sv
// rtl/tec8_timing_gen.sv - phase/beat sequencer with run control and IR/C/Z registers
module tec8_timing_gen
  import tec8_pkg::*;
#(
  parameter int QD_SYNC_STAGES = 2,
  parameter bit RUN_ON_RESET   = 1'b0
) (
  input  logic            clk_i,
  input  logic            clr_i,
  input  logic            qd_i,
  input  logic            short_i,
  input  logic            long_i,
  input  logic            stop_i,
  input  logic            lir_i,
  input  logic            ldc_i,
  input  logic            ldz_i,
  input  logic [7:0]      ins_in_i,
  input  logic            alu_cout_i,
  input  logic            alu_zero_i,
  output logic            t1_o,
  output logic            t2_o,
  output logic            t3_o,
  output logic            w1_o,
  output logic            w2_o,
  output logic            w3_o,
  output logic [IR_W-1:0] ir_o,
  output logic            c_o,
  output logic            z_o,
  output logic            running_o
);

  logic qd_rise;

  tec8_pulse_sync #(
    .STAGES (QD_SYNC_STAGES)
  ) u_qd_sync (
    .clk_i   (clk_i),
    .clr_i   (clr_i),
    .async_i (qd_i),
    .rise_o  (qd_rise)
  );

  phase_e          phase_q, phase_d;
  beat_e           beat_q,  beat_d;
  logic            run_q,   run_d;
  logic [IR_W-1:0] ir_q,    ir_d;
  logic            c_q,     c_d;
  logic            z_q,     z_d;
  logic            t1_q, t2_q, t3_q;
  logic            w1_q, w2_q, w3_q;

  logic unused_ins_low;
  assign unused_ins_low = ^ins_in_i[7-IR_W:0];

  always_comb begin
    phase_d = phase_q;
    beat_d  = beat_q;
    run_d   = run_q;
    ir_d    = ir_q;
    c_d     = c_q;
    z_d     = z_q;
    if (run_q) begin
      if (phase_q == T3) begin
        beat_d  = next_beat(beat_q, short_i, long_i);
        phase_d = T1;
        if (stop_i) run_d = 1'b0;
        if (lir_i)  ir_d  = ins_in_i[7 -: IR_W];
        if (ldc_i)  c_d   = alu_cout_i;
        if (ldz_i)  z_d   = alu_zero_i;
      end else begin
        phase_d = (phase_q == T1) ? T2 : T3;
      end
    end else if (qd_rise) begin
      // a start edge seen while running is dropped, which also lets stop@T3 win
      run_d   = 1'b1;
      phase_d = T1;
    end
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      phase_q <= T1;
      beat_q  <= W1;
      run_q   <= RUN_ON_RESET;
      ir_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      t1_q    <= RUN_ON_RESET;
      t2_q    <= 1'b0;
      t3_q    <= 1'b0;
      w1_q    <= 1'b1;
      w2_q    <= 1'b0;
      w3_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      beat_q  <= beat_d;
      run_q   <= run_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
      z_q     <= z_d;
      t1_q    <= run_d && (phase_d == T1);
      t2_q    <= run_d && (phase_d == T2);
      t3_q    <= run_d && (phase_d == T3);
      w1_q    <= (beat_d == W1);
      w2_q    <= (beat_d == W2);
      w3_q    <= (beat_d == W3);
    end
  end

  assign t1_o      = t1_q;
  assign t2_o      = t2_q;
  assign t3_o      = t3_q;
  assign w1_o      = w1_q;
  assign w2_o      = w2_q;
  assign w3_o      = w3_q;
  assign ir_o      = ir_q;
  assign c_o       = c_q;
  assign z_o       = z_q;
  assign running_o = run_q;

endmodule

// File: tb/tb_tec8_timing_gen.sv
// tb/tb_tec8_timing_gen.sv - randomized and directed self-checking bench for tec8_timing_gen
module tb_tec8_timing_gen;
  import tec8_pkg::*;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       clr, qd, sh, lg, stp, lir, ldc, ldz, acout, azero;
  logic [7:0] ins;
  logic       t1, t2, t3, w1, w2, w3, c, z, running;
  logic [3:0] ir;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tec8_timing_gen #(
    .QD_SYNC_STAGES (SYNC),
    .RUN_ON_RESET   (1'b0)
  ) dut (
    .clk_i      (clk),
    .clr_i      (clr),
    .qd_i       (qd),
    .short_i    (sh),
    .long_i     (lg),
    .stop_i     (stp),
    .lir_i      (lir),
    .ldc_i      (ldc),
    .ldz_i      (ldz),
    .ins_in_i   (ins),
    .alu_cout_i (acout),
    .alu_zero_i (azero),
    .t1_o       (t1),
    .t2_o       (t2),
    .t3_o       (t3),
    .w1_o       (w1),
    .w2_o       (w2),
    .w3_o       (w3),
    .ir_o       (ir),
    .c_o        (c),
    .z_o        (z),
    .running_o  (running)
  );

  // reference: phase/beat as small integers, qd as a history of sampled levels
  int          m_phase, m_beat;
  bit          m_run, m_start;
  logic [3:0]  m_ir;
  logic        m_c, m_z;
  logic [SYNC:0] qh;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_phase = 0; m_beat = 0; m_run = 0;
      m_ir = 4'h0; m_c = 1'b0; m_z = 1'b0;
      qh = '0;
    end else begin
      m_start = qh[SYNC-1] && !qh[SYNC];
      qh = {qh[SYNC-1:0], qd};
      if (m_run) begin
        if (m_phase == 2) begin
          if (lir) m_ir = ins[7:4];
          if (ldc) m_c = acout;
          if (ldz) m_z = azero;
          if (m_beat == 0)      m_beat = sh ? 0 : 1;
          else if (m_beat == 1) m_beat = lg ? 2 : 0;
          else                  m_beat = 0;
          m_phase = 0;
          if (stp) m_run = 0;
        end else begin
          m_phase = m_phase + 1;
        end
      end else if (m_start) begin
        m_run = 1;
        m_phase = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      chk("cmp_t", {5'd0, t3, t2, t1}, m_run ? (8'd1 << m_phase) : 8'd0);
      chk("cmp_w", {5'd0, w3, w2, w1}, 8'd1 << m_beat);
      chk("cmp_running", {7'd0, running}, {7'd0, m_run});
      chk("cmp_ir", {4'd0, ir}, {4'd0, m_ir});
      chk("cmp_cz", {6'd0, c, z}, {6'd0, m_c, m_z});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sh = 0; lg = 0; stp = 0; lir = 0; ldc = 0; ldz = 0;
  endtask

  // b < 0 matches any beat
  task automatic wait_state(input int p, input int b, input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 80; i++) begin
      if (m_run && m_phase == p && (b < 0 || m_beat == b)) begin
        found = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_%s timed out", name);
    end
  endtask

  initial begin
    clr = 1; qd = 0; ins = 8'h00; acout = 0; azero = 0;
    idle_inputs();
    tick(); tick();
    chk("rst_t", {5'd0, t3, t2, t1}, 8'h00);
    chk("rst_w", {5'd0, w3, w2, w1}, 8'h01);
    chk("rst_run_ir_cz", {running, ir, 1'b0, c, z}, 8'h00);
    clr = 0;
    tick(); tick();
    chk("halted_after_reset", {7'd0, running}, 8'h00);

    qd = 1;
    tick(); tick();
    chk("qd_latency_2clk", {7'd0, t1}, 8'h00);
    tick();
    chk("qd_latency_3clk", {7'd0, t1}, 8'h01);
    tick(); tick();
    qd = 0;

    sh = 1;
    repeat (12) tick();
    chk("short_holds_w1", {5'd0, w3, w2, w1}, 8'h01);
    sh = 0;

    wait_state(2, 0, "lir");
    ins = 8'hA5; lir = 1;
    tick();
    lir = 0; ins = 8'h00;
    chk("lir_w1_t3", {4'd0, ir}, 8'h0A);
    wait_state(1, -1, "lir_t2");
    ins = 8'h35; lir = 1;
    tick();
    lir = 0; ins = 8'h00;
    chk("lir_t2_ignored", {4'd0, ir}, 8'h0A);

    wait_state(2, -1, "ldcz");
    ldc = 1; ldz = 1; acout = 1; azero = 0;
    tick();
    ldc = 0; ldz = 0;
    chk("ldc_ldz", {6'd0, c, z}, 8'h02);
    wait_state(2, -1, "ldz_only");
    ldz = 1; azero = 1; acout = 0;
    tick();
    ldz = 0;
    chk("ldz_only", {6'd0, c, z}, 8'h03);

    wait_state(2, 1, "long");
    lg = 1;
    tick();
    lg = 0;
    chk("long_w3", {5'd0, w3, w2, w1}, 8'h04);
    repeat (3) tick();
    chk("w3_to_w1", {5'd0, w3, w2, w1}, 8'h01);
    wait_state(2, 0, "short_long");
    sh = 1; lg = 1;
    tick();
    idle_inputs();
    chk("short_wins", {5'd0, w3, w2, w1}, 8'h01);

    wait_state(2, 1, "stop");
    stp = 1;
    tick();
    stp = 0;
    chk("stop_t", {5'd0, t3, t2, t1}, 8'h00);
    chk("stop_w1_run", {4'd0, w3, w2, w1, running}, 8'h02);
    repeat (20) tick();
    chk("halt_hold_regs", {running, ir, 1'b0, c, z}, 8'h53);

    qd = 1;
    repeat (3) tick();
    chk("resume_w1_t1", {2'd0, w3, w2, w1, t3, t2, t1}, 8'h09);
    repeat (2) tick();
    qd = 0;

    wait_state(0, -1, "coincide");
    qd = 1;
    tick(); tick();
    stp = 1;
    tick();
    stp = 0;
    chk("stop_beats_qd", {7'd0, running}, 8'h00);
    repeat (5) tick();
    chk("qd_held_no_restart", {7'd0, running}, 8'h00);
    qd = 0;
    tick();
    qd = 1;
    repeat (3) tick();
    qd = 0;

    repeat (1500) begin
      sh    = ($urandom_range(0, 3) == 0);
      lg    = ($urandom_range(0, 1) == 0);
      stp   = ($urandom_range(0, 24) == 0);
      lir   = ($urandom_range(0, 2) == 0);
      ldc   = ($urandom_range(0, 2) == 0);
      ldz   = ($urandom_range(0, 2) == 0);
      ins   = 8'($urandom);
      acout = 1'($urandom);
      azero = 1'($urandom);
      if ($urandom_range(0, 5) == 0) qd = ~qd;
      tick();
    end
    idle_inputs();
    qd = 0;
    tick(); tick();
    if (!m_run) begin
      qd = 1;
      repeat (3) tick();
      qd = 0;
    end

    wait_state(1, 1, "clr_w2t2");
    #1;
    clr = 1;
    #1;
    chk("clr_async_t", {5'd0, t3, t2, t1}, 8'h00);
    chk("clr_async_w", {5'd0, w3, w2, w1}, 8'h01);
    chk("clr_async_regs", {running, ir, 1'b0, c, z}, 8'h00);
    tick();
    clr = 0;
    repeat (6) tick();
    chk("post_clr_halted", {2'd0, w3, w2, w1, t3, t2, t1}, 8'h08);
    chk("post_clr_running", {7'd0, running}, 8'h00);
    qd = 1;
    repeat (3) tick();
    chk("post_clr_start", {7'd0, t1}, 8'h01);
    qd = 0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
